// File: rtl/flow_sum_arbiter.sv
// Purpose: round-robin share of one zero-terminated stream accumulator between N requesters.
// Latency: grant 1 cycle after req, response 1 cycle after the accumulator's done (zero-first: 2 cycles after req).
// Backpressure: non-granted requesters hold req and their first word until granted; one stream in flight at a time.
//
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   req, reqData         per-requester request and word (slice i = reqData[i*W +: W])
//   gnt                  one-hot grant; reqData[i] consumed on each edge where gnt[i]=1
//   rspValid/Sum/Error/Abort  one-cycle response strobe per requester plus captured result
//   accGo, accIn         drive the shared accumulator
//   accDone, accError, accSum  accumulator result, valid combinationally in the done cycle
module flow_sum_arbiter #(
    parameter int N      = 4,
    parameter int W      = 16,
    parameter int MAXLEN = 255
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] reqData,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rspValid,
    output logic [W-1:0]   rspSum,
    output logic           rspError,
    output logic           rspAbort,
    output logic           accGo,
    output logic [W-1:0]   accIn,
    input  logic           accDone,
    input  logic           accError,
    input  logic [W-1:0]   accSum
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic [SW-1:0] pick;
    logic          pick_vld;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sel_dat;
    logic          force_end;

    // First requester at or after the pointer, wrapping. The loop walks
    // backwards so the lowest offset from the pointer is the last writer.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                pick_vld = 1'b1;
                pick     = SW'((int'(ptr) + i) % N);
            end
        end
    end

    assign sel_dat = reqData[int'(sel) * W +: W];

    // cnt holds the number of words already consumed, so reaching MAXLEN
    // means the word on the bus now would exceed the limit.
    assign force_end = (state == RUN) && (!req[sel] || (cnt >= CW'(MAXLEN)));

    assign accGo = (state == START);

    always_comb begin
        accIn = '0;
        if (state == START || (state == RUN && !force_end)) begin
            accIn = sel_dat;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rspValid <= '0;
            rspSum   <= '0;
            rspError <= 1'b0;
            rspAbort <= 1'b0;
        end else begin
            rspValid <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel   <= pick;
                        gnt   <= N'(1) << pick;
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    cnt <= CW'(1);
                    if (sel_dat == '0) begin
                        // Empty stream: the accumulator is not consulted.
                        gnt      <= '0;
                        rspValid <= N'(1) << sel;
                        rspSum   <= '0;
                        rspError <= 1'b0;
                        rspAbort <= 1'b0;
                        state    <= RESP;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != CW'(MAXLEN)) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (accDone) begin
                        gnt      <= '0;
                        rspValid <= N'(1) << sel;
                        rspSum   <= accSum;
                        rspError <= accError;
                        rspAbort <= force_end;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flow_sum_arbiter.sv
module tb_flow_sum_arbiter;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int MAXLEN = 4;

    logic           clk = 1'b0;
    logic           rstN;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rspValid;
    logic [W-1:0]   rspSum;
    logic           rspError;
    logic           rspAbort;
    logic           accGo;
    logic [W-1:0]   accIn;
    logic           accDone;
    logic           accError;
    logic [W-1:0]   accSum;

    int errors = 0;
    int checks = 0;

    // Requester word queues: qm[i][qh[i] .. qt[i]-1] are still to be consumed.
    logic [W-1:0] qm [N][16];
    int           qh [N];
    int           qt [N];
    int           m_ptr;

    always #5 clk = ~clk;

    flow_sum_arbiter #(.N(N), .W(W), .MAXLEN(MAXLEN)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .req      (req),
        .reqData  (reqData),
        .gnt      (gnt),
        .rspValid (rspValid),
        .rspSum   (rspSum),
        .rspError (rspError),
        .rspAbort (rspAbort),
        .accGo    (accGo),
        .accIn    (accIn),
        .accDone  (accDone),
        .accError (accError),
        .accSum   (accSum)
    );

    // Stand-in accumulator: go loads the first word, later words add with a
    // sticky carry-out flag, a 0 after the first word ends the stream.
    logic [W-1:0] a_sum;
    logic         a_err;
    logic         a_act;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_sum <= '0;
            a_err <= 1'b0;
            a_act <= 1'b0;
        end else if (accGo) begin
            a_sum <= accIn;
            a_err <= 1'b0;
            a_act <= (accIn != '0);
        end else if (a_act) begin
            if (accIn == '0) begin
                a_act <= 1'b0;
            end else begin
                a_sum <= a_sum + accIn;
                if (a_sum > ~accIn) a_err <= 1'b1;
            end
        end
    end

    assign accDone  = a_act && !accGo && (accIn == '0);
    assign accSum   = a_sum;
    assign accError = a_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q(input int i);
        qh[i] = 0;
        qt[i] = 0;
    endtask

    task automatic push(input int i, input logic [W-1:0] w);
        qm[i][qt[i]] = w;
        qt[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (qt[i] > qh[i]) begin
                req[i]              = 1'b1;
                reqData[i*W +: W]   = qm[i][qh[i]];
            end else begin
                req[i]              = 1'b0;
                reqData[i*W +: W]   = '0;
            end
        end
    endtask

    // Called mid-cycle: whatever is granted now is consumed at the next edge.
    task automatic tick();
        logic [N-1:0] pm;
        pm = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pm[i] && qt[i] > qh[i]) qh[i]++;
        end
        drive();
    endtask

    // One arbitration round, called just after a rising edge while the
    // arbiter sits in IDLE. Expectations come from the queue contents.
    task automatic stream();
        int           sel;
        int           size0;
        int           total;
        int           len;
        logic         abort;
        logic [W-1:0] pres [MAXLEN+1];
        logic [N-1:0] eg;

        sel = -1;
        for (int k = 0; k < N; k++) begin
            if (sel < 0 && qt[(m_ptr + k) % N] > qh[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        end
        if (sel < 0) return;

        size0   = qt[sel] - qh[sel];
        abort   = 1'b0;
        pres[0] = qm[sel][qh[sel]];
        total   = int'(pres[0]);
        len     = 1;
        if (pres[0] != '0) begin
            for (int j = 1; j <= MAXLEN; j++) begin
                len = j + 1;
                if (j >= size0 || j >= MAXLEN) begin
                    pres[j] = '0;
                    abort   = 1'b1;
                    break;
                end
                pres[j] = qm[sel][qh[sel] + j];
                total  += int'(pres[j]);
                if (pres[j] == '0) break;
            end
        end
        eg = N'(1) << sel;

        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'(0));
        chk("idle_accIn", 32'(accIn), 32'(0));
        tick();
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            chk($sformatf("gnt_w%0d_req%0d", j, sel), 32'(gnt), 32'(eg));
            chk($sformatf("accGo_w%0d", j), 32'(accGo), (j == 0) ? 32'(1) : 32'(0));
            chk($sformatf("accIn_w%0d", j), 32'(accIn), 32'(pres[j]));
            chk($sformatf("rspValid_w%0d", j), 32'(rspValid), 32'(0));
            tick();
        end
        @(negedge clk);
        chk($sformatf("rspValid_req%0d", sel), 32'(rspValid), 32'(eg));
        chk("rspSum", 32'(rspSum), 32'(total % 65536));
        chk("rspError", 32'(rspError), (total >= 65536) ? 32'(1) : 32'(0));
        chk("rspAbort", 32'(rspAbort), 32'(abort));
        chk("resp_gnt", 32'(gnt), 32'(0));
        chk("resp_accGo", 32'(accGo), 32'(0));
        tick();
        m_ptr = (sel + 1) % N;
    endtask

    task automatic fill_random(input int i);
        int n;
        clear_q(i);
        n = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) push(i, W'($urandom_range(16'hC000, 16'hFFFF)));
            else                           push(i, W'($urandom_range(1, 200)));
        end
        if ($urandom_range(0, 4) != 0 || qt[i] == 0) push(i, '0);
    endtask

    initial begin
        rstN    = 1'b1;
        req     = '0;
        reqData = '0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) clear_q(i);
        #1 rstN = 1'b0;
        #11;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rspValid", 32'(rspValid), 32'(0));
        chk("rst_rspSum", 32'(rspSum), 32'(0));
        chk("rst_rspError", 32'(rspError), 32'(0));
        chk("rst_rspAbort", 32'(rspAbort), 32'(0));
        chk("rst_accGo", 32'(accGo), 32'(0));
        chk("rst_accIn", 32'(accIn), 32'(0));
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Single stream 7, 3, 0 on requester 0.
        push(0, 16'd7); push(0, 16'd3); push(0, 16'd0);
        drive();
        stream();

        // Overflow on requester 3.
        push(3, 16'hFFFF); push(3, 16'h0002); push(3, 16'h0001); push(3, 16'h0000);
        drive();
        stream();

        // Contention: all four at the same edge, served in pointer order.
        for (int i = 0; i < N; i++) begin
            push(i, 16'd1); push(i, 16'd0);
        end
        drive();
        for (int i = 0; i < N; i++) stream();

        // Requesters 1 and 2 reissue together; pointer order decides.
        push(1, 16'd2); push(1, 16'd0);
        push(2, 16'd3); push(2, 16'd0);
        drive();
        stream();
        stream();

        // Zero-first stream on requester 2.
        push(2, 16'd0);
        drive();
        stream();

        // Length limit: six 1s with req held high; drop the leftover afterwards.
        for (int k = 0; k < 6; k++) push(0, 16'd1);
        drive();
        stream();
        clear_q(0);
        drive();

        // Requester drops after words 5, 5.
        push(1, 16'd5); push(1, 16'd5);
        drive();
        stream();

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            int busy;
            for (int i = 0; i < N; i++) begin
                if (qt[i] == qh[i] && $urandom_range(0, 2) == 0) fill_random(i);
            end
            busy = 0;
            for (int i = 0; i < N; i++) if (qt[i] > qh[i]) busy = 1;
            if (busy == 0) fill_random(int'($urandom_range(0, N - 1)));
            drive();
            stream();
        end

        // Reset during the second word of a stream.
        for (int i = 0; i < N; i++) clear_q(i);
        push(1, 16'd4); push(1, 16'd6); push(1, 16'd0);
        drive();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("pre_rst_accGo", 32'(accGo), 32'(1));
        tick();
        @(negedge clk);
        chk("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
        #2 rstN = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'(0));
        chk("midrst_accGo", 32'(accGo), 32'(0));
        chk("midrst_accIn", 32'(accIn), 32'(0));
        chk("midrst_rspValid", 32'(rspValid), 32'(0));
        for (int i = 0; i < N; i++) clear_q(i);
        drive();
        m_ptr = 0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_rspValid", 32'(rspValid), 32'(0));
            chk("postrst_gnt", 32'(gnt), 32'(0));
        end
        @(posedge clk);
        #1;
        push(3, 16'd9); push(3, 16'd0);
        drive();
        stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
